// File: rtl/t03_bus_arbiter.sv
// Two-port bus arbiter: the data port wins over instruction fetch, one transaction at a time.
// Each transaction issues a single strobe, waits for busy_o to drop (bounded by TIMEOUT) and returns a one-cycle ack.
module t03_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_sel,
    input  logic        busy_o,
    input  logic [31:0] cpu_dat_o,
    output logic        read_i,
    output logic        write_i,
    output logic [31:0] adr_i,
    output logic [31:0] cpu_dat_i,
    output logic [3:0]  sel_i,
    output logic        i_ack,
    output logic        d_ack,
    output logic [31:0] i_rdata,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        grant_d
);

    localparam int CW = (TIMEOUT < 2) ? 2 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state;
    state_t          state_nx;
    logic            owner_d;
    logic            lat_we;
    logic [CW-1:0]   wait_cnt;
    logic            ack_pending;
    logic            grant_data;
    logic            grant_instr;
    logic            wait_ok;
    logic            wait_to;
    logic            finish;
    logic [31:0]     fin_data;

    assign grant_d = owner_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A timeout ack is raised while already in IDLE; holding off grants for that
    // cycle stops the still-asserted request from being served a second time.
    always_comb begin
        ack_pending = i_ack | d_ack;
        grant_data  = 1'b0;
        grant_instr = 1'b0;
        wait_ok     = 1'b0;
        wait_to     = 1'b0;
        state_nx    = state;
        case (state)
            IDLE: begin
                grant_data  = en && d_req && !ack_pending;
                grant_instr = en && !d_req && i_req && !ack_pending;
                if (grant_data || grant_instr) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                state_nx = WAIT;
            end
            WAIT: begin
                wait_ok = !busy_o && (wait_cnt >= CW'(2));
                wait_to = busy_o && (wait_cnt >= TMAX);
                if (wait_ok) begin
                    state_nx = DONE;
                end else if (wait_to) begin
                    state_nx = IDLE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        finish   = wait_ok || wait_to;
        fin_data = wait_to ? 32'hFFFF_FFFF : cpu_dat_o;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_i    <= 1'b0;
            write_i   <= 1'b0;
            adr_i     <= 32'h0;
            cpu_dat_i <= 32'h0;
            sel_i     <= 4'h0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= 32'h0;
            d_rdata   <= 32'h0;
            err       <= 1'b0;
            owner_d   <= 1'b0;
            lat_we    <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            read_i  <= 1'b0;
            write_i <= 1'b0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;

            if (grant_data) begin
                owner_d   <= 1'b1;
                lat_we    <= d_we;
                adr_i     <= d_addr;
                sel_i     <= d_sel;
                cpu_dat_i <= d_we ? d_wdata : 32'h0;
                read_i    <= !d_we;
                write_i   <= d_we;
            end else if (grant_instr) begin
                owner_d   <= 1'b0;
                lat_we    <= 1'b0;
                adr_i     <= i_addr;
                sel_i     <= 4'hF;
                cpu_dat_i <= 32'h0;
                read_i    <= 1'b1;
            end

            if (state == ISSUE) begin
                wait_cnt <= CW'(1);
            end else if ((state == WAIT) && (wait_cnt < TMAX)) begin
                wait_cnt <= wait_cnt + CW'(1);
            end

            if (finish) begin
                if (wait_to) begin
                    err <= 1'b1;
                end
                if (owner_d) begin
                    d_ack <= 1'b1;
                    if (!lat_we) begin
                        d_rdata <= fin_data;
                    end
                end else begin
                    i_ack   <= 1'b1;
                    i_rdata <= fin_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_t03_bus_arbiter.sv
// Scoreboard bench for t03_bus_arbiter: stimulus pushes expected strobes/acks,
// a negedge monitor pops and compares whenever the DUT strobes or acks.
module tb_t03_bus_arbiter;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        en;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_sel;
    logic        busy_o;
    logic [31:0] cpu_dat_o;
    logic        read_i;
    logic        write_i;
    logic [31:0] adr_i;
    logic [31:0] cpu_dat_i;
    logic [3:0]  sel_i;
    logic        i_ack;
    logic        d_ack;
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
    logic        err;
    logic        grant_d;

    t03_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .en(en),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
        .busy_o(busy_o), .cpu_dat_o(cpu_dat_o),
        .read_i(read_i), .write_i(write_i), .adr_i(adr_i), .cpu_dat_i(cpu_dat_i), .sel_i(sel_i),
        .i_ack(i_ack), .d_ack(d_ack), .i_rdata(i_rdata), .d_rdata(d_rdata),
        .err(err), .grant_d(grant_d)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        gd;
    } strobe_t;

    typedef struct {
        logic        is_d;
        logic [31:0] exp_i;
        logic [31:0] exp_d;
        logic        exp_err;
        int          delta;
    } ack_t;

    typedef struct {
        int          busy_len;
        logic [31:0] data;
    } plan_t;

    strobe_t strobe_q[$];
    ack_t    ack_q[$];
    plan_t   plan_q[$];

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_i_rdata = 32'h0;
    logic [31:0] m_d_rdata = 32'h0;
    logic        m_err = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a granted transaction shows one strobe, then the ack arrives
    // after the WAIT length implied by the busy time (or the timeout), plus DONE.
    task automatic modelTxn(input logic is_d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] sel,
                            input int blen, input logic [31:0] data, input logic with_ack);
        strobe_t s;
        plan_t   p;
        ack_t    a;
        logic    tmo;
        int      w;
        s.rd  = !(is_d && we);
        s.wr  = is_d && we;
        s.adr = addr;
        s.sel = is_d ? sel : 4'hF;
        s.dat = (is_d && we) ? wdata : 32'h0;
        s.gd  = is_d;
        strobe_q.push_back(s);
        p.busy_len = blen;
        p.data     = data;
        plan_q.push_back(p);
        tmo = (blen >= TO);
        w   = tmo ? TO : ((blen + 1 < 2) ? 2 : blen + 1);
        if (with_ack) begin
            if (tmo) m_err = 1'b1;
            if (!(is_d && we)) begin
                if (is_d) m_d_rdata = tmo ? 32'hFFFF_FFFF : data;
                else      m_i_rdata = tmo ? 32'hFFFF_FFFF : data;
            end
            a.is_d    = is_d;
            a.exp_i   = m_i_rdata;
            a.exp_d   = m_d_rdata;
            a.exp_err = m_err;
            a.delta   = w + 1;
            ack_q.push_back(a);
        end
    endtask

    // Bus side: after each strobe keep busy_o high for the planned number of WAIT cycles.
    always begin
        plan_t pl;
        @(negedge clock);
        if (!reset && (read_i || write_i)) begin
            pl.busy_len = 0;
            pl.data     = 32'h0;
            if (plan_q.size() != 0) pl = plan_q.pop_front();
            cpu_dat_o = pl.data;
            for (int k = 1; k < 40; k++) begin
                @(negedge clock);
                if (reset || i_ack || d_ack) break;
                busy_o = (k <= pl.busy_len);
            end
            busy_o = 1'b0;
        end
    end

    int          cyc = 0;
    int          strobe_cyc = 0;
    logic        in_txn = 1'b0;
    logic [31:0] held_adr = 32'h0;
    strobe_t     ms;
    ack_t        ma;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            in_txn = 1'b0;
        end else begin
            if (read_i || write_i) begin
                checkOutput("strobe_expected", 32'(strobe_q.size() != 0), 32'd1);
                if (strobe_q.size() != 0) begin
                    ms = strobe_q.pop_front();
                    checkOutput("read_i", 32'(read_i), 32'(ms.rd));
                    checkOutput("write_i", 32'(write_i), 32'(ms.wr));
                    checkOutput("adr_i", adr_i, ms.adr);
                    checkOutput("sel_i", 32'(sel_i), 32'(ms.sel));
                    checkOutput("cpu_dat_i", cpu_dat_i, ms.dat);
                    checkOutput("grant_d", 32'(grant_d), 32'(ms.gd));
                    held_adr = ms.adr;
                end
                strobe_cyc = cyc;
                in_txn = 1'b1;
            end else if (in_txn) begin
                checkOutput("adr_hold", adr_i, held_adr);
            end
            if (i_ack || d_ack) begin
                in_txn = 1'b0;
                checkOutput("ack_expected", 32'(ack_q.size() != 0), 32'd1);
                if (ack_q.size() != 0) begin
                    ma = ack_q.pop_front();
                    checkOutput("i_ack", 32'(i_ack), 32'(!ma.is_d));
                    checkOutput("d_ack", 32'(d_ack), 32'(ma.is_d));
                    checkOutput("i_rdata", i_rdata, ma.exp_i);
                    checkOutput("d_rdata", d_rdata, ma.exp_d);
                    checkOutput("err", 32'(err), 32'(ma.exp_err));
                    checkOutput("ack_latency", 32'(cyc - strobe_cyc), 32'(ma.delta));
                end
            end
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_read_i"}, 32'(read_i), 32'd0);
        checkOutput({tag, "_write_i"}, 32'(write_i), 32'd0);
        checkOutput({tag, "_adr_i"}, adr_i, 32'd0);
        checkOutput({tag, "_cpu_dat_i"}, cpu_dat_i, 32'd0);
        checkOutput({tag, "_sel_i"}, 32'(sel_i), 32'd0);
        checkOutput({tag, "_acks"}, 32'({i_ack, d_ack}), 32'd0);
        checkOutput({tag, "_i_rdata"}, i_rdata, 32'd0);
        checkOutput({tag, "_d_rdata"}, d_rdata, 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_grant_d"}, 32'(grant_d), 32'd0);
    endtask

    // Requester side: hold each request until its ack; after a grant, scramble the
    // served port's inputs to show the in-flight transaction is latched.
    task automatic waitAcks(input logic drop_en);
        int n = 0;
        while ((i_req || d_req) && n < 300) begin
            @(negedge clock);
            n++;
            if (read_i || write_i) begin
                if (drop_en) en = 1'b0;
                if (grant_d) begin
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                    d_sel   = 4'($urandom);
                    d_we    = 1'($urandom);
                end else begin
                    i_addr = $urandom;
                end
            end
            if (d_ack) d_req = 1'b0;
            if (i_ack) i_req = 1'b0;
        end
        checkOutput("ack_wait", 32'(i_req || d_req), 32'd0);
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    // kind: 0 = fetch only, 1 = data only, 2 = both in the same cycle
    task automatic applyStimulus(input int kind, input logic [31:0] ia, input logic [31:0] da,
                                 input logic dwe, input logic [31:0] dwd, input logic [3:0] ds,
                                 input int bi, input logic [31:0] ri, input int bd, input logic [31:0] rd);
        @(negedge clock);
        if (kind != 0) modelTxn(1'b1, dwe, da, dwd, ds, bd, rd, 1'b1);
        if (kind != 1) modelTxn(1'b0, 1'b0, ia, 32'h0, 4'hF, bi, ri, 1'b1);
        i_addr  = ia;
        d_addr  = da;
        d_we    = dwe;
        d_wdata = dwd;
        d_sel   = ds;
        d_req   = (kind != 0);
        i_req   = (kind != 1);
        en      = 1'b1;
        waitAcks(1'b0);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1; en = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_sel = 4'h0;
        busy_o = 1'b0; cpu_dat_o = 32'h0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkResetState("reset");

        // Single fetch, then data beating a simultaneous fetch, then a store.
        applyStimulus(0, 32'h100, 32'h0, 1'b0, 32'h0, 4'h0, 3, 32'h0050_0093, 0, 32'h0);
        applyStimulus(2, 32'h104, 32'h2000, 1'b0, 32'h0, 4'hF, 1, 32'h1111_2222, 2, 32'hA5A5_0001);
        applyStimulus(1, 32'h0, 32'h3004, 1'b1, 32'hDEAD_BEEF, 4'b0001, 0, 32'h0, 0, 32'h7777_7777);

        // Busy held past the timeout on a data load.
        applyStimulus(1, 32'h0, 32'h4000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 20, 32'h1234_5678);

        // Fetch held while disabled: no strobe until en returns.
        @(negedge clock);
        en = 1'b0; i_addr = 32'h400; i_req = 1'b1;
        repeat (6) @(negedge clock);
        modelTxn(1'b0, 1'b0, 32'h400, 32'h0, 4'hF, 4, 32'hCAFE_0001, 1'b1);
        en = 1'b1;
        waitAcks(1'b1);
        i_addr = 32'h500; i_req = 1'b1;
        repeat (6) @(negedge clock);
        modelTxn(1'b0, 1'b0, 32'h500, 32'h0, 4'hF, 2, 32'hCAFE_0002, 1'b1);
        en = 1'b1;
        waitAcks(1'b0);

        // Reset during WAIT: strobe expected, ack must never appear.
        @(negedge clock);
        modelTxn(1'b0, 1'b0, 32'h600, 32'h0, 4'hF, 6, 32'h0000_1234, 1'b0);
        i_addr = 32'h600; i_req = 1'b1; en = 1'b1;
        n = 0;
        while (!read_i && n < 20) begin
            @(negedge clock);
            n++;
        end
        checkOutput("wait_reset_strobe", 32'(read_i), 32'd1);
        repeat (2) @(negedge clock);
        reset = 1'b1; i_req = 1'b0;
        @(negedge clock);
        checkResetState("midreset");
        @(negedge clock);
        reset = 1'b0;
        m_i_rdata = 32'h0; m_d_rdata = 32'h0; m_err = 1'b0;
        applyStimulus(0, 32'h700, 32'h0, 1'b0, 32'h0, 4'h0, 2, 32'h0BAD_F00D, 0, 32'h0);

        // Randomized mix, some long enough to time out.
        for (int t = 0; t < 40; t++) begin
            applyStimulus($urandom_range(0, 2), $urandom, $urandom, 1'($urandom), $urandom,
                          4'($urandom), $urandom_range(0, 10), $urandom,
                          $urandom_range(0, 10), $urandom);
        end

        repeat (4) @(negedge clock);
        checkOutput("strobe_q_drained", 32'(strobe_q.size()), 32'd0);
        checkOutput("ack_q_drained", 32'(ack_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
